// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with start/done handshake and flush abort.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic              r_neg;
  logic              r_negr;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_sa;
  logic              w_sb;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_quo_next;
  logic [XLEN-1:0]   w_final;
  logic              w_last;

  // Operand signedness, magnitudes and special-case detection at start
  always_comb begin
    w_sa          = !(op == 3'b011 || op == 3'b101 || op == 3'b111);
    w_sb          = (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b110);
    w_a_neg       = w_sa & rs1[XLEN-1];
    w_b_neg       = w_sb & rs2[XLEN-1];
    w_abs_a       = w_a_neg ? -rs1 : rs1;
    w_abs_b       = w_b_neg ? -rs2 : rs2;
    w_zero        = (rs2 == {XLEN{1'b0}});
    w_ovf         = !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
    w_special     = op[2] && (w_zero || w_ovf);
    w_special_res = {XLEN{1'b0}};
    if (w_zero)
      w_special_res = op[1] ? rs1 : {XLEN{1'b1}};
    else
      w_special_res = op[1] ? {XLEN{1'b0}} : rs1;
  end

  // One iteration of shift-add multiply and restoring divide, plus final fixup
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_a};
    w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
    w_prod_s   = r_neg ? -w_mul_next : w_mul_next;
    // Divide reuses the low accumulator half as dividend/quotient shift register
    w_shift    = {r_rem, r_acc[XLEN-1]};
    w_diff     = w_shift - {1'b0, r_b};
    w_ge       = !w_diff[XLEN];
    w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    w_quo_next = {r_acc[XLEN-2:0], w_ge};
    w_last     = (r_cnt == CW'(XLEN-1));
    w_final    = {XLEN{1'b0}};
    case (r_op)
      3'b000:                 w_final = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = r_neg ? -w_quo_next : w_quo_next;
      default:                w_final = r_negr ? -w_rem_next : w_rem_next;
    endcase
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_neg    <= 1'b0;
      r_negr   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_CALC: begin
            if (r_op[2]) begin
              r_acc[XLEN-1:0] <= w_quo_next;
              r_rem           <= w_rem_next;
            end else begin
              r_acc <= w_mul_next;
            end
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_final;
            end
          end
          default: begin
            if (start) begin
              r_op   <= op;
              r_a    <= w_abs_a;
              r_b    <= w_abs_b;
              r_neg  <= w_a_neg ^ w_b_neg;
              r_negr <= w_a_neg;
              r_cnt  <= '0;
              r_rem  <= '0;
              r_acc  <= {{XLEN{1'b0}}, (op[2] ? w_abs_a : w_abs_b)};
              if (w_special) begin
                r_state  <= S_DONE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_result <= w_special_res;
              end else begin
                r_state <= S_CALC;
                r_busy  <= 1'b1;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level behavioural model, per-cycle compare,
// directed test-plan cases with literal results, and randomized traffic.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    p  = '0;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Model: cycles of busy remaining, expected done and result
  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_cnt = 0;
      m_res = '0;
    end else if (flush) begin
      m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else if (start) begin
      if (is_special(op, rs1, rs2)) begin
        m_done = 1'b1;
        m_res  = ref_result(op, rs1, rs2);
      end else begin
        m_cnt  = XLEN;
        m_pend = ref_result(op, rs1, rs2);
      end
    end
    m_busy = (m_cnt > 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy", 32'(busy), 32'(m_busy));
      check("cyc done", 32'(done), 32'(m_done));
      check("cyc result", result, m_res);
    end
  end

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    op = f; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    check({name, " model"}, ref_result(f, a, b), exp);
    start_op(f, a, b);
    wait_done(lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " result"}, result, exp);
  endtask

  task automatic count_pulses(input int cycles, output int n_busy, output int n_done);
    n_busy = 0; n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (done) n_done++;
    end
  endtask

  initial begin
    int lat, nb, nd;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);

    run_op("MUL", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("MULH", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("DIV", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("REM", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIV by 0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("REMU by 0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // Flush mid-divide
    run_op("pre flush", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    @(negedge clk);
    start_op(3'd5, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("flush busy before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy after", 32'(busy), 32'd0);
    check("flush result", result, 32'd14);
    count_pulses(40, nb, nd);
    check("flush no done", 32'(nd), 32'd0);
    check("flush result hold", result, 32'd14);
    run_op("MUL after flush", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);

    // Reset mid-divide
    @(negedge clk);
    start_op(3'd5, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", result, 32'd0);
    count_pulses(40, nb, nd);
    check("rst no done", 32'(nd), 32'd0);
    run_op("MUL after rst", 3'd0, 32'd123, 32'd456, 32'h0000DB18, 33);

    // Start while busy is ignored
    @(negedge clk);
    start_op(3'd0, 32'd7, 32'hFFFFFFFD);
    repeat (4) @(negedge clk);
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("calc start latency", 32'(lat), 32'd28);
    check("calc start result", result, 32'hFFFFFFEB);
    @(negedge clk);
    check("calc start no op busy", 32'(busy), 32'd0);
    check("calc start no op done", 32'(done), 32'd0);

    // Start together with flush is dropped
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    count_pulses(40, nb, nd);
    check("start+flush busy", 32'(nb), 32'd0);
    check("start+flush done", 32'(nd), 32'd0);
    check("start+flush result", result, 32'hFFFFFFEB);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      op = 3'($urandom);
      case ($urandom_range(0, 5))
        0: rs1 = 32'h0;
        1: rs1 = 32'hFFFFFFFF;
        2: rs1 = 32'h80000000;
        3: rs1 = $urandom_range(0, 15);
        default: rs1 = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rs2 = 32'h0;
        1: rs2 = 32'hFFFFFFFF;
        2: rs2 = 32'h80000000;
        3: rs2 = $urandom_range(0, 15);
        default: rs2 = $urandom;
      endcase
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit with a parameterised data width. It sits beside the ALU in the EX stage of the five-stage pipelined CPU and adds MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, which the single-cycle ALU does not provide. It uses a start/done handshake so the hazard logic can stall IF/ID/EX while a multi-cycle operation runs. It also accepts a flush so that a taken branch or jump in ID can abort an in-flight operation.

## Interface
Parameters:
- XLEN, 32, operand and result width; must be even and ≥ 8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  EX presents a valid M-extension op this cycle.
- flush  in  1  abort the current or in-flight op; no done is produced.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A (multiplicand/dividend).
- rs2  in  XLEN  operand B (multiplier/divisor).
- busy  out  1  high while state is CALC; the pipeline holds EX and ID while busy.
- done  out  1  one-cycle pulse; result valid in this cycle.
- result  out  XLEN  final result; holds its value until the next accepted start.

## Operation
State machine:
- IDLE → CALC on an accepted start for a normal op.
- IDLE → DONE on an accepted start for a special-case op.
- CALC → DONE when the step counter reaches XLEN−1.
- DONE → IDLE, or DONE → CALC/DONE if a new start is accepted.

Start handling:
- start is accepted only in IDLE or DONE.
- start in CALC is ignored; the pipeline is already stalled.

Capture on an accepted start:
- op is latched.
- |rs1| and |rs2| are latched, with a signed/unsigned interpretation chosen per op (rs1 signed for MUL/MULH/MULHSU/DIV/REM; rs2 signed for MUL/MULH/DIV/REM).
- Result-sign flags are latched.
- Step counter is cleared to 0.

Multiply:
- Unsigned shift-add, one multiplier bit per cycle, into a 2·XLEN accumulator.
- At completion the product is negated if exactly one operand was negative.
- MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.

Divide:
- Restoring division, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
- Quotient is negated if the operand signs differ (DIV only).
- Remainder takes the dividend's sign (REM only).

Special cases (no CALC, go directly to DONE):
- Divisor = 0: DIV/DIVU result = all ones; REM/REMU result = rs1.
- Signed overflow, DIV/REM with rs1 = 1<<(XLEN−1) and rs2 = all ones: DIV result = rs1; REM result = 0.

Arithmetic rules:
- All arithmetic is modulo 2^XLEN (2^(2·XLEN) for the product).
- Negation is two's complement.
- The most-negative value passes through unchanged.

## Timing
Reset:
- State goes to IDLE and the counter to 0.
- busy = 0, done = 0, result = 0.
- Applies on the next edge, from any state, including mid-operation.

Latency (start sampled at edge 0):
- Normal op: busy = 1 in cycles 1..XLEN; done = 1 in cycle XLEN+1 (33 for XLEN=32).
- Special case: busy never rises; done = 1 in cycle 1.

Handshake:
- done lasts exactly one cycle.
- result is registered and becomes valid in the same cycle as done.
- result stays stable until the next accepted start.

Back-to-back:
- A start in the DONE cycle is accepted, so there is no idle bubble.
- The done pulse of the previous op is still produced in that cycle.

Flush:
- flush in any state forces IDLE at the next edge.
- done stays 0 and result is unchanged.
- flush together with start: flush wins and the start is dropped.
- flush in the DONE cycle: done has already been asserted that cycle; the unit goes to IDLE afterwards.

Inputs and outputs:
- rs1, rs2 and op are sampled only on an accepted start and may change freely afterwards.
- There is no combinational path from any input to busy, done or result.

## Test plan
(XLEN=32 throughout.)
- MUL: rs1=7, rs2=0xFFFFFFFD → done at cycle 33, result=0xFFFFFFEB; busy high in cycles 1–32.
- High-half products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF at cycle 1, busy never high.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Abort paths:
  - flush at cycle 10 of a DIVU → busy=0 at cycle 11, no done pulse, result unchanged.
  - A new MUL started afterwards completes correctly.
  - Repeat with reset in place of flush; result must read 0.
- Handshake:
  - start asserted in CALC → ignored, the original op's result is unchanged.
  - start asserted in the DONE cycle → second op's done arrives exactly 33 cycles later.
  - start asserted together with flush → no operation starts.
